// File: rtl/idstage.sv
// rv32i decode stage: register file, immediate build and registered EX handoff.
// Build option: define WB_BYPASS_EN to forward same-cycle writeback data instead of stalling.
module idstage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            instr_ready_o,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [2:0]      alu_op_o,
  output logic            alu_alt_op_o,
  output logic [XLEN-1:0] operand1_o,
  output logic [XLEN-1:0] operand2_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  logic [XLEN-1:0] rf_q [NREGS];

  logic            valid_q;
  logic [2:0]      op_q;
  logic            alt_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [4:0]      rd_q;
  logic            ill_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, hit1, hit2, stall, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic [2:0]      d_op;
  logic            d_alt, d_ill;
  logic [XLEN-1:0] d_op1, d_op2;
  logic [4:0]      d_rd;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign use_rs1 = (opcode == OpcOp) || (opcode == OpcOpImm);
  assign use_rs2 = (opcode == OpcOp);
  assign hit1    = wb_en_i && (wb_rd_i != 5'd0) && use_rs1 && (wb_rd_i == rs1);
  assign hit2    = wb_en_i && (wb_rd_i != 5'd0) && use_rs2 && (wb_rd_i == rs2);

`ifdef WB_BYPASS_EN
  assign rs1_val = hit1 ? wb_data_i : ((rs1 == 5'd0) ? '0 : rf_q[rs1]);
  assign rs2_val = hit2 ? wb_data_i : ((rs2 == 5'd0) ? '0 : rf_q[rs2]);
  assign stall   = 1'b0;
`else
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign stall   = hit1 || hit2;
`endif

  assign instr_ready_o = !flush_i && !stall && (!valid_q || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    d_op  = funct3;
    d_alt = 1'b0;
    d_op1 = '0;
    d_op2 = '0;
    d_rd  = rd;
    d_ill = 1'b0;
    case (opcode)
      OpcOp: begin
        d_alt = funct7[5];
        d_op1 = rs1_val;
        d_op2 = rs2_val;
        d_ill = !((funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OpcOpImm: begin
        d_op1 = rs1_val;
        d_op2 = {{20{instr_i[31]}}, instr_i[31:20]};
        // Shifts hand EX the bare shamt so the SRAI marker bit does not leak into op2.
        if (funct3 == 3'b001) begin
          d_op2 = {27'd0, rs2};
          d_ill = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          d_alt = instr_i[30];
          d_op2 = {27'd0, rs2};
          d_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OpcLui: begin
        d_op  = 3'b000;
        d_op2 = {instr_i[31:12], 12'd0};
      end
      OpcAuipc: begin
        d_op  = 3'b000;
        d_op1 = pc_i;
        d_op2 = {instr_i[31:12], 12'd0};
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_op  = 3'b000;
      d_alt = 1'b0;
      d_op1 = '0;
      d_op2 = '0;
      d_rd  = 5'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      valid_q <= 1'b0;
      op_q    <= 3'b000;
      alt_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= 5'd0;
      ill_q   <= 1'b0;
    end else begin
      if (wb_en_i && (wb_rd_i != 5'd0)) rf_q[wb_rd_i] <= wb_data_i;
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        op_q    <= d_op;
        alt_q   <= d_alt;
        op1_q   <= d_op1;
        op2_q   <= d_op2;
        rd_q    <= d_rd;
        ill_q   <= d_ill;
      end else if (ex_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid_o   = valid_q;
  assign alu_op_o     = op_q;
  assign alu_alt_op_o = alt_q;
  assign operand1_o   = op1_q;
  assign operand2_o   = op2_q;
  assign rd_o         = rd_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_idstage.sv
// Self-checking bench for idstage: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the decode stage.
module tb_idstage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, flush, ex_ready, wb_en;
  logic [31:0] instr, pc, wb_data;
  logic [4:0]  wb_rd;
  logic        instr_ready, ex_valid, alu_alt, illegal;
  logic [2:0]  alu_op;
  logic [31:0] op1, op2;
  logic [4:0]  rd;

  int checks   = 0;
  int failures = 0;
  logic last_ready;

  always #5 clk = ~clk;

  idstage dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_valid_i(instr_valid),
    .instr_i      (instr),
    .pc_i         (pc),
    .instr_ready_o(instr_ready),
    .flush_i      (flush),
    .ex_valid_o   (ex_valid),
    .ex_ready_i   (ex_ready),
    .alu_op_o     (alu_op),
    .alu_alt_op_o (alu_alt),
    .operand1_o   (op1),
    .operand2_o   (op2),
    .rd_o         (rd),
    .illegal_o    (illegal),
    .wb_en_i      (wb_en),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  op;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } dec_t;

  logic [31:0] m_rf [32];
  dec_t        m_out;
  logic        m_valid = 1'b0;

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_out = '0;
  end

  function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] a, input logic [31:0] b);
    dec_t d;
    logic [6:0] opc = ins[6:0];
    logic [6:0] f7  = ins[31:25];
    logic [2:0] f3  = ins[14:12];
    logic legal;
    logic [31:0] sext_imm = 32'(signed'(ins[31:20]));
    logic [31:0] upper = ins & 32'hFFFF_F000;
    d = '0;
    d.rd = ins[11:7];
    legal = 1'b1;
    if (opc == 7'h33) begin
      legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      d.op = f3; d.alt = f7[5]; d.a = a; d.b = b;
    end else if (opc == 7'h13) begin
      d.op = f3; d.a = a;
      if (f3 == 1) begin
        legal = (f7 == 0); d.b = 32'(ins[24:20]);
      end else if (f3 == 5) begin
        legal = (f7 == 0) || (f7 == 7'h20); d.alt = ins[30]; d.b = 32'(ins[24:20]);
      end else begin
        d.b = sext_imm;
      end
    end else if (opc == 7'h37) begin
      d.b = upper;
    end else if (opc == 7'h17) begin
      d.a = pcv; d.b = upper;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      d = '0;
      d.ill = 1'b1;
    end
    return d;
  endfunction

  // Compare process: checks DUT against the model, then advances the model by one edge.
  always @(negedge clk) begin
    logic [4:0]  s1, s2;
    logic        u1, u2, h1, h2, stall, m_ready;
    logic [31:0] va, vb;
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("alu_op", 32'(alu_op), 32'(m_out.op));
    chk("alu_alt", 32'(alu_alt), 32'(m_out.alt));
    chk("operand1", op1, m_out.a);
    chk("operand2", op2, m_out.b);
    chk("rd", 32'(rd), 32'(m_out.rd));
    chk("illegal", 32'(illegal), 32'(m_out.ill));

    s1 = instr[19:15];
    s2 = instr[24:20];
    u1 = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h13);
    u2 = (instr[6:0] == 7'h33);
    h1 = wb_en && wb_rd != 0 && u1 && wb_rd == s1;
    h2 = wb_en && wb_rd != 0 && u2 && wb_rd == s2;
    va = m_rf[s1];
    vb = m_rf[s2];
`ifdef WB_BYPASS_EN
    if (h1) va = wb_data;
    if (h2) vb = wb_data;
    stall = 1'b0;
`else
    stall = h1 || h2;
`endif
    m_ready = !flush && !stall && (!m_valid || ex_ready);
    if (!rst) chk("instr_ready", 32'(instr_ready), 32'(m_ready));

    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_valid = 1'b0;
      m_out   = '0;
    end else begin
      if (flush) m_valid = 1'b0;
      else if (instr_valid && m_ready) begin
        m_valid = 1'b1;
        m_out   = model_decode(instr, pc, va, vb);
      end else if (ex_ready) m_valid = 1'b0;
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'h13};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                      input logic fl, input logic er, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd);
    instr_valid = v; instr = ins; pc = pcv; flush = fl; ex_ready = er;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #1 last_ready = instr_ready;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] eop, input logic ealt,
                            input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] erd);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
    chk({tag, ".op"}, 32'(alu_op), 32'(eop));
    chk({tag, ".alt"}, 32'(alu_alt), 32'(ealt));
    chk({tag, ".op1"}, op1, ea);
    chk({tag, ".op2"}, op2, eb);
    chk({tag, ".rd"}, 32'(rd), 32'(erd));
  endtask

  initial begin
    logic [31:0] a_ins, b_ins, add7, r;
    rst = 1'b1;
    instr_valid = 0; instr = 0; pc = 0; flush = 0; ex_ready = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; last_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.valid", 32'(ex_valid), 0);
    chk("reset.op1", op1, 0);
    chk("reset.illegal", 32'(illegal), 0);

    step(1, 32'hFFB00093, 0, 0, 1, 0, 0, 0);
    expect_out("addi", 3'd0, 0, 32'h0, 32'hFFFFFFFB, 5'd1);

    step(0, 0, 0, 0, 1, 1, 5'd2, 32'd7);
    step(0, 0, 0, 0, 1, 1, 5'd3, 32'd3);
    step(1, enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd4), 0, 0, 1, 0, 0, 0);
    expect_out("sub", 3'd0, 1, 32'd7, 32'd3, 5'd4);
    step(1, enc_i({7'h20, 5'd3}, 5'd2, 3'd5, 5'd5), 0, 0, 1, 0, 0, 0);
    expect_out("srai", 3'd5, 1, 32'd7, 32'd3, 5'd5);

    // Backpressure: A held while B waits.
    a_ins = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd10);
    b_ins = enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd11);
    step(1, a_ins, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, b_ins, 0, 0, 0, 0, 0, 0);
      chk("bp.ready", 32'(last_ready), 0);
      expect_out("bp.hold", 3'd0, 0, 32'd7, 32'd3, 5'd10);
    end
    step(1, b_ins, 0, 0, 1, 0, 0, 0);
    expect_out("bp.drain", 3'd0, 1, 32'd7, 32'd3, 5'd11);

    // Same-cycle writeback of a source register.
    add7 = enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd7);
    step(1, add7, 0, 0, 1, 1, 5'd6, 32'h55);
`ifdef WB_BYPASS_EN
    chk("raw.ready", 32'(last_ready), 1);
`else
    chk("raw.ready", 32'(last_ready), 0);
    step(1, add7, 0, 0, 1, 0, 0, 0);
    chk("raw.ready2", 32'(last_ready), 1);
`endif
    expect_out("raw", 3'd0, 0, 32'h55, 32'h0, 5'd7);

    step(1, 32'h0000006F, 0, 0, 1, 0, 0, 0);
    chk("jal.illegal", 32'(illegal), 1);
    expect_out("jal", 3'd0, 0, 32'h0, 32'h0, 5'd0);
    step(1, 32'hFFB00093, 0, 1, 0, 0, 0, 0);
    chk("flush.ready", 32'(last_ready), 0);
    chk("flush.valid", 32'(ex_valid), 0);

    step(1, 32'h12345417, 32'h100, 0, 1, 0, 0, 0);
    expect_out("auipc", 3'd0, 0, 32'h100, 32'h12345000, 5'd8);
    step(0, 0, 0, 0, 1, 1, 5'd0, 32'hDEAD);
    step(1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9), 0, 0, 1, 0, 0, 0);
    expect_out("x0", 3'd0, 0, 32'h0, 32'h0, 5'd9);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 6))
        0: r = enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom),
                     3'($urandom), 5'($urandom));
        1: begin r = $urandom; r[6:0] = 7'h33; end
        2: begin r = $urandom; r[6:0] = 7'h13; end
        3: r = enc_i({($urandom_range(0, 3) == 0) ? 7'($urandom) :
                      ($urandom_range(0, 1) ? 7'h20 : 7'h00), 5'($urandom)},
                     5'($urandom), $urandom_range(0, 1) ? 3'd1 : 3'd5, 5'($urandom));
        4: begin r = $urandom; r[6:0] = 7'h37; end
        5: begin r = $urandom; r[6:0] = 7'h17; end
        default: r = $urandom;
      endcase
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 9) < 7, r, $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom);
    end
    rst = 1'b0;
    step(0, 0, 0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
